// File: rtl/pipe_hit_scanner.sv
// Per-frame obstacle scanner: walks the five on-screen slots one per clock,
// flagging pipe collisions, collecting coins once per pipe, and counting passes.
module pipe_hit_scanner #(
  parameter int unsigned BIRD_X   = 100,
  parameter int unsigned BIRD_W   = 20,
  parameter int unsigned BIRD_H   = 20,
  parameter int unsigned PIPE_W   = 40,
  parameter int unsigned COIN_OFF = 10,
  parameter int unsigned COIN_SZ  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [9:0]  bird_y,
  input  logic [49:0] pipe_x,
  input  logic [49:0] edge_t,
  input  logic [49:0] edge_b,
  input  logic [49:0] coin_y,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic        coin_pulse,
  output logic [7:0]  coin_count,
  output logic [7:0]  pass_count
);

  localparam logic [10:0] L_BX = 11'(BIRD_X);
  localparam logic [10:0] L_BW = 11'(BIRD_W);
  localparam logic [10:0] L_BH = 11'(BIRD_H);
  localparam logic [10:0] L_PW = 11'(PIPE_W);
  localparam logic [10:0] L_CO = 11'(COIN_OFF);
  localparam logic [10:0] L_CS = 11'(COIN_SZ);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT, S_HALT} state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_idx;
  logic [4:0]  r_taken, r_passed;
  logic [9:0]  r_last_x [5];
  logic        r_f_hit;
  logic [2:0]  r_f_coins;
  logic        r_hit;
  logic [7:0]  r_coin_count, r_pass_count;

  logic [9:0]  w_px [5];
  logic [9:0]  w_pt [5];
  logic [9:0]  w_pb [5];
  logic [9:0]  w_pc [5];

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_slot
      assign w_px[gi] = pipe_x[10*gi +: 10];
      assign w_pt[gi] = edge_t[10*gi +: 10];
      assign w_pb[gi] = edge_b[10*gi +: 10];
      assign w_pc[gi] = coin_y[10*gi +: 10];
    end
  endgenerate

  // Everything widened to 11 bits so sums of 10-bit coordinates never wrap.
  logic [10:0] w_x, w_t, w_b, w_cy, w_by, w_cx;
  logic        w_new, w_taken_eff, w_passed_eff;
  logic        w_hov, w_vhit, w_coin, w_pass;
  logic [8:0]  w_coin_sum;

  assign w_x  = {1'b0, w_px[r_idx]};
  assign w_t  = {1'b0, w_pt[r_idx]};
  assign w_b  = {1'b0, w_pb[r_idx]};
  assign w_cy = {1'b0, w_pc[r_idx]};
  assign w_by = {1'b0, bird_y};
  assign w_cx = w_x + L_CO;

  // A pipe whose x moved right has respawned, so its per-slot history is stale.
  assign w_new        = w_px[r_idx] > r_last_x[r_idx];
  assign w_taken_eff  = r_taken[r_idx]  & ~w_new;
  assign w_passed_eff = r_passed[r_idx] & ~w_new;

  assign w_hov  = (w_x < L_BX + L_BW) && (w_x + L_PW > L_BX);
  assign w_vhit = (w_by < w_t) || (w_by + L_BH > w_b);
  assign w_coin = (w_cy != 11'd0) && !w_taken_eff &&
                  (w_cx < L_BX + L_BW) && (w_cx + L_CS > L_BX) &&
                  (w_by < w_cy + L_CS) && (w_by + L_BH > w_cy);
  assign w_pass = (w_x + L_PW <= L_BX) && !w_passed_eff;

  assign w_coin_sum = {1'b0, r_coin_count} + {6'd0, r_f_coins};

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    coin_pulse   = 1'b0;
    case (r_state)
      S_IDLE:   if (frame_tick) w_state_next = S_SCAN;
      S_SCAN: begin
        busy = 1'b1;
        if (r_idx == 3'd4) w_state_next = S_REPORT;
      end
      S_REPORT: begin
        busy         = 1'b1;
        done         = 1'b1;
        coin_pulse   = (r_f_coins != 3'd0);
        w_state_next = r_f_hit ? S_HALT : S_IDLE;
      end
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx        <= 3'd0;
      r_taken      <= 5'd0;
      r_passed     <= 5'd0;
      r_f_hit      <= 1'b0;
      r_f_coins    <= 3'd0;
      r_hit        <= 1'b0;
      r_coin_count <= 8'd0;
      r_pass_count <= 8'd0;
      for (int i = 0; i < 5; i++) r_last_x[i] <= 10'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_idx     <= 3'd0;
            r_f_hit   <= 1'b0;
            r_f_coins <= 3'd0;
          end
        end
        S_SCAN: begin
          r_idx            <= r_idx + 3'd1;
          r_last_x[r_idx]  <= w_px[r_idx];
          r_taken[r_idx]   <= w_taken_eff | w_coin;
          r_passed[r_idx]  <= w_passed_eff | w_pass;
          if (w_hov && w_vhit) r_f_hit <= 1'b1;
          if (w_coin) r_f_coins <= r_f_coins + 3'd1;
          if (w_pass && r_pass_count != 8'hFF) r_pass_count <= r_pass_count + 8'd1;
        end
        S_REPORT: begin
          r_coin_count <= w_coin_sum[8] ? 8'hFF : w_coin_sum[7:0];
          if (r_f_hit) r_hit <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hit        = r_hit;
  assign coin_count = r_coin_count;
  assign pass_count = r_pass_count;

endmodule

// File: tb/tb_pipe_hit_scanner.sv
// Scoreboard bench for pipe_hit_scanner: a frame-level reference model queues the
// expected report; a monitor compares whenever done is seen.
module tb_pipe_hit_scanner;

  localparam int BX = 100, BW = 20, BH = 20, PW = 40, CO = 10, CS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  bird_y = '0;
  logic [49:0] pipe_x = '0, edge_t = '0, edge_b = '0, coin_y = '0;
  logic        busy, done, hit, coin_pulse;
  logic [7:0]  coin_count, pass_count;

  pipe_hit_scanner dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .bird_y(bird_y),
    .pipe_x(pipe_x), .edge_t(edge_t), .edge_b(edge_b), .coin_y(coin_y),
    .busy(busy), .done(done), .hit(hit), .coin_pulse(coin_pulse),
    .coin_count(coin_count), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit pulse;
    bit hit;
    int coins;
    int passes;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_last [5];
  bit m_taken [5];
  bit m_passed [5];
  int m_coin, m_pass;
  bit m_hit;

  // Stimulus for the next frame
  int s_px [5], s_et [5], s_eb [5], s_cy [5];
  int s_by;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_last[i] = 0; m_taken[i] = 0; m_passed[i] = 0;
    end
    m_coin = 0; m_pass = 0; m_hit = 0;
  endtask

  task automatic model_frame(output exp_t e);
    int fc = 0;
    bit fh = 0;
    int x;
    for (int i = 0; i < 5; i++) begin
      x = s_px[i];
      if (x > m_last[i]) begin
        m_taken[i] = 0; m_passed[i] = 0;
      end
      m_last[i] = x;
      if (x < BX + BW && x + PW > BX && (s_by < s_et[i] || s_by + BH > s_eb[i])) fh = 1;
      if (s_cy[i] != 0 && !m_taken[i] && x + CO < BX + BW && x + CO + CS > BX &&
          s_by < s_cy[i] + CS && s_by + BH > s_cy[i]) begin
        m_taken[i] = 1; fc++;
      end
      if (x + PW <= BX && !m_passed[i]) begin
        m_passed[i] = 1;
        if (m_pass < 255) m_pass++;
      end
    end
    m_coin = (m_coin + fc > 255) ? 255 : m_coin + fc;
    if (fh) m_hit = 1;
    e.cyc = 0; e.pulse = (fc != 0); e.hit = m_hit; e.coins = m_coin; e.passes = m_pass;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < 5; i++) begin
      pipe_x[10*i +: 10] = 10'(s_px[i]);
      edge_t[10*i +: 10] = 10'(s_et[i]);
      edge_b[10*i +: 10] = 10'(s_eb[i]);
      coin_y[10*i +: 10] = 10'(s_cy[i]);
    end
    bird_y = 10'(s_by);
  endtask

  task automatic set_far();
    for (int i = 0; i < 5; i++) begin
      s_px[i] = 600; s_et[i] = 50; s_eb[i] = 250; s_cy[i] = 0;
    end
    s_by = 100;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_coin_pulse"}, coin_pulse, 0);
    chk({tag, "_coin_count"}, coin_count, 0);
    chk({tag, "_pass_count"}, pass_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One frame; 'extra' re-pulses frame_tick during the scan, which must be ignored.
  task automatic do_frame(input bit extra);
    exp_t e;
    int t0;
    @(negedge clk);
    apply_inputs();
    frame_tick = 1'b1;
    t0 = cyc;
    if (!m_hit) begin
      model_frame(e);
      e.cyc = t0 + 6;
      q.push_back(e);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      frame_tick = extra && (k == 2 || k == 4);
    end
    frame_tick = 1'b0;
    chk("scoreboard_drained", q.size(), 0);
    q.delete();
    chk("idle_busy", busy, 0);
  endtask

  task automatic midscan_reset();
    @(negedge clk);
    apply_inputs();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_zero("midscan");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  always begin : monitor
    exp_t e;
    @(negedge clk);
    if (reset && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("coin_pulse", coin_pulse, e.pulse);
        @(posedge clk);
        #1;
        chk("hit", hit, e.hit);
        chk("coin_count", coin_count, e.coins);
        chk("pass_count", pass_count, e.passes);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    set_far();
    repeat (2) @(posedge clk);
    do_reset();

    // Clear pass, twice to show no HALT
    set_far(); s_px[0] = 90; s_by = 100;
    do_frame(0);
    do_frame(0);

    // Top collision, then a frame_tick in HALT, then reset
    s_by = 40;
    do_frame(0);
    do_frame(0);
    do_reset();

    // Coin taken once per pipe, re-armed on respawn
    set_far(); s_px[2] = 95; s_cy[2] = 120; s_by = 110;
    do_frame(0);
    do_frame(0);
    s_px[2] = 300; do_frame(0);
    s_px[2] = 95;  do_frame(0);

    // Pass counting
    set_far(); s_px[1] = 70; s_by = 100;
    do_frame(0);
    s_px[1] = 60; do_frame(0);
    s_px[1] = 50; do_frame(0);

    // Drive pass_count into saturation
    for (int p = 0; p < 53; p++) begin
      set_far(); do_frame(0);
      for (int i = 0; i < 5; i++) s_px[i] = 50;
      do_frame(0);
    end

    // Busy ignore
    set_far(); s_px[0] = 90; s_by = 100;
    do_frame(1);

    // Reset mid-scan with a pending hit, then a normal frame
    set_far(); s_px[0] = 90; s_by = 40;
    midscan_reset();
    s_by = 100;
    do_frame(0);

    // Randomized frames
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < 5; i++) begin
        s_px[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(30, 160))
                                               : int'($urandom_range(0, 700));
        s_et[i] = $urandom_range(20, 120);
        s_eb[i] = s_et[i] + int'($urandom_range(80, 200));
        s_cy[i] = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(60, 260));
      end
      s_by = $urandom_range(40, 220);
      do_frame($urandom_range(0, 3) == 0);
      if (m_hit) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hit_scanner.md
Name: pipe_hit_scanner

Overview:
Consumer of the per-slot pipe edges and coin heights produced by the obstacle height table. Once per frame it scans the five on-screen obstacle slots, one slot per clock, against the bird's bounding box. It flags a pipe collision, collects coins once each, and counts pipes passed, feeding the game-state FSM and the score display.

Parameters:
BIRD_X, 100, fixed left x of bird box
BIRD_W, 20, bird box width
BIRD_H, 20, bird box height
PIPE_W, 40, pipe width
COIN_OFF, 10, coin x offset from pipe left edge
COIN_SZ, 16, coin box side

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
frame_tick  in  1  start-scan strobe, sampled in IDLE only
bird_y  in  10  bird box top y
pipe_x  in  50  slot i left x at [10i+9:10i]
edge_t  in  50  slot i gap top y
edge_b  in  50  slot i gap bottom y
coin_y  in  50  slot i coin top y; 0 = no coin
busy  out  1  high in SCAN/REPORT
done  out  1  one-cycle pulse in REPORT
hit  out  1  sticky collision flag
coin_pulse  out  1  high with done if at least one coin was taken this frame
coin_count  out  8  saturating coins collected
pass_count  out  8  saturating pipes passed

Behaviour:
- Reset (reset==0 at posedge): state IDLE, idx=0. All outputs 0. Per-slot taken[4:0]=0, passed[4:0]=0, last_x[i]=0. Reset mid-scan aborts the scan with no updates.
- All compares use 11-bit unsigned arithmetic, so no wrap.
- FSM states: IDLE, SCAN, REPORT, HALT.
- IDLE: when frame_tick=1, go to SCAN with idx=0 and clear the frame accumulators (f_hit, f_coins[2:0]). A frame_tick outside IDLE is ignored.
- SCAN: on each cycle, evaluate slot idx.
  - New pipe: if x > last_x[idx], clear taken[idx] and passed[idx] before evaluating. Then last_x[idx] <= x.
  - Pipe horizontal overlap: x < BIRD_X+BIRD_W and x+PIPE_W > BIRD_X.
  - Vertical hit: bird_y < edge_t or bird_y+BIRD_H > edge_b.
  - If horizontal overlap and vertical hit, set f_hit.
  - Coin: coin x cx = x+COIN_OFF. Overlap when coin_y≠0, !taken[idx], cx < BIRD_X+BIRD_W, cx+COIN_SZ > BIRD_X, bird_y < coin_y+COIN_SZ, and bird_y+BIRD_H > coin_y. On overlap, set taken[idx] and increment f_coins.
  - Pass: if x+PIPE_W <= BIRD_X and !passed[idx], set passed[idx] and increment pass_count (saturate at 255).
  - After idx=4, go to REPORT.
- REPORT (one cycle):
  - done=1.
  - coin_count += f_coins, saturating at 255.
  - coin_pulse = (f_coins≠0).
  - If f_hit, set hit=1 and go to HALT; otherwise go to IDLE.
- Latency: frame_tick at cycle 0 → SCAN cycles 1–5 → done/coin_pulse at cycle 6. Counters and hit are visible from cycle 7.
- HALT: busy=0, done=0. Holds hit and both counts. Leaves only on reset.
- Inputs must be stable from the frame_tick cycle through the last SCAN cycle. Changes during SCAN affect only slots not yet scanned.
- A coin taken in a slot cannot be recounted until that slot's x increases (pipe respawned at the right).
- A hit and a coin in the same slot are both registered, so coin_count updates even on the fatal frame.

Test Plan:
- Clear pass: slot0 x=90, t=50, b=250, bird_y=100, others x=600, coin_y=0; pulse frame_tick → done at cycle 6, hit=0, coin_count=0, HALT not entered.
- Top collision: same setup but bird_y=40 → hit=1 after REPORT. A later frame_tick gives no done. reset=0 for one cycle → hit=0, IDLE.
- Coin once: slot2 x=95, t=50, b=250, coin_y=120, bird_y=110. Two frames with x unchanged → coin_count=1, coin_pulse only on the first done. Then x=300 followed by x=95 → count=2.
- Pass counting: slot1 x=70 (70+40 > 100, no pass), then x=60 → pass_count=1. Repeat x=50 → stays 1. Preload 255 passes, then pass again → stays 255.
- Reset mid-scan: assert reset at SCAN cycle 3 with a pending hit → all outputs 0 next cycle. The next frame_tick scans normally.
- Busy ignore: frame_tick asserted at cycles 2 and 4 of a scan → exactly one done per scan.
